// File: rtl/wb_master_bridge.sv
// Single-outstanding command/response to Wishbone classic master bridge.
// A watchdog counter ends any access whose responder never acknowledges.
module wb_master_bridge #(
  parameter int ADDRWIDTH          = 10,
  parameter int DATAWIDTH          = 32,
  parameter int TIMEOUT_CNTR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 15,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_RD_VALUE = 32'hDEF_FAB_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 CMD_VALID_i,
  output logic                 CMD_READY_o,
  input  logic                 CMD_WE_i,
  input  logic [ADDRWIDTH-1:0] CMD_ADR_i,
  input  logic [DATAWIDTH-1:0] CMD_DAT_i,
  input  logic [3:0]           CMD_SEL_i,
  output logic                 RSP_VALID_o,
  input  logic                 RSP_READY_i,
  output logic [DATAWIDTH-1:0] RSP_DAT_o,
  output logic                 RSP_ERR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic [3:0]           WBm_SEL_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNTR_LOAD = TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNTR_LAST = TIMEOUT_CNTR_WIDTH'(1);

  state_t                        state_reg;
  logic [TIMEOUT_CNTR_WIDTH-1:0] cntr_reg;

  // Ready is the only combinational output so a waiting command is taken with no bubble.
  assign CMD_READY_o = (state_reg == IDLE);

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      state_reg   <= IDLE;
      cntr_reg    <= CNTR_LOAD;
      WBm_CYC_o   <= 1'b0;
      WBm_STB_o   <= 1'b0;
      WBm_WE_o    <= 1'b0;
      WBm_ADR_o   <= '0;
      WBm_SEL_o   <= '0;
      WBm_DAT_o   <= '0;
      RSP_VALID_o <= 1'b0;
      RSP_ERR_o   <= 1'b0;
      RSP_DAT_o   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (CMD_VALID_i) begin
            state_reg <= BUS;
            cntr_reg  <= CNTR_LOAD;
            WBm_CYC_o <= 1'b1;
            WBm_STB_o <= 1'b1;
            WBm_WE_o  <= CMD_WE_i;
            WBm_ADR_o <= CMD_ADR_i;
            WBm_SEL_o <= CMD_SEL_i;
            WBm_DAT_o <= CMD_DAT_i;
          end
        end
        BUS: begin
          if (WBm_ACK_i) begin
            // An acknowledge wins even on the cycle the watchdog would expire.
            state_reg   <= RESP;
            WBm_CYC_o   <= 1'b0;
            WBm_STB_o   <= 1'b0;
            RSP_VALID_o <= 1'b1;
            RSP_ERR_o   <= 1'b0;
            RSP_DAT_o   <= WBm_WE_o ? '0 : WBm_DAT_i;
          end else begin
            if (cntr_reg != '0) begin
              cntr_reg <= cntr_reg - CNTR_LAST;
            end
            if (cntr_reg == CNTR_LAST) begin
              state_reg   <= RESP;
              WBm_CYC_o   <= 1'b0;
              WBm_STB_o   <= 1'b0;
              RSP_VALID_o <= 1'b1;
              RSP_ERR_o   <= 1'b1;
              RSP_DAT_o   <= WBm_WE_o ? '0 : TIMEOUT_RD_VALUE;
            end
          end
        end
        RESP: begin
          if (RSP_READY_i) begin
            state_reg   <= IDLE;
            RSP_VALID_o <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          WBm_CYC_o   <= 1'b0;
          WBm_STB_o   <= 1'b0;
          RSP_VALID_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
